multi_accumulate: RTL

MULTI_ACCUMULATE -- requirements
Module: multi_accumulate

---
 rtl/accum_pkg.sv | 23 ++
 rtl/accum_lane.sv | 84 ++++++++
 rtl/multi_accumulate.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// ============================================================================
//  Module      : accum_pkg
//  Description : Shared constants for the multi-channel accumulator: the
//                arithmetic mode selectors and the dump FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_pkg;

  // Arithmetic behaviour of every accumulator lane
  localparam int MODE_WRAP = 0;  // modulo 2^WIDTH, flag on signed overflow
  localparam int MODE_SAT  = 1;  // clamp to [LOW, HIGH], flag on clamping

  // Top-level controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,  // accepting samples
    ST_DUMP = 1'b1   // streaming sums out, samples blocked
  } state_e;

endpackage

`default_nettype wire

// File: rtl/accum_lane.sv
// ============================================================================
//  Module      : accum_lane
//  Description : One accumulator channel: a signed sum register, a sticky
//                overflow/saturation flag and a wrap-or-saturate adder.
//  Ports       : clk, rst      - clock / synchronous active-high reset
//                add_en_i      - add add_i into the sum on this edge
//                add_i         - signed addend
//                clear_i       - return sum to LOW and drop the flag
//                sum_o, ovf_o  - current sum and sticky flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_lane
  import accum_pkg::*;
#(
  parameter int                      WIDTH = 16,
  parameter int                      MODE  = MODE_WRAP,
  parameter logic signed [WIDTH-1:0] HIGH  = {1'b0, {(WIDTH-1){1'b1}}},
  parameter logic signed [WIDTH-1:0] LOW   = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    add_en_i,
  input  logic signed [WIDTH-1:0] add_i,
  input  logic                    clear_i,
  output logic signed [WIDTH-1:0] sum_o,
  output logic                    ovf_o
);

  // Bounds sign-extended to the adder width so the clamp compares are exact
  localparam logic signed [WIDTH:0] HIGH_X = {HIGH[WIDTH-1], HIGH};
  localparam logic signed [WIDTH:0] LOW_X  = {LOW[WIDTH-1], LOW};

  logic signed [WIDTH-1:0] sum_q, sum_d;
  logic                    ovf_q, ovf_d;
  logic signed [WIDTH:0]   wide_sum;

  // One extra bit of headroom: the true sum of two WIDTH-bit values always fits
  assign wide_sum = {sum_q[WIDTH-1], sum_q} + {add_i[WIDTH-1], add_i};

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      sum_d = LOW;
      ovf_d = 1'b0;
    end else if (add_en_i) begin
      if (MODE == MODE_SAT) begin
        if (wide_sum > HIGH_X) begin
          sum_d = HIGH;
          ovf_d = 1'b1;
        end else if (wide_sum < LOW_X) begin
          sum_d = LOW;
          ovf_d = 1'b1;
        end else begin
          sum_d = wide_sum[WIDTH-1:0];
        end
      end else begin
        sum_d = wide_sum[WIDTH-1:0];
        // Top two bits disagree exactly when the result left WIDTH-bit range
        if (wide_sum[WIDTH] != wide_sum[WIDTH-1]) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= LOW;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/multi_accumulate.sv
// ============================================================================
//  Module      : multi_accumulate
//  Description : CHANNELS independent signed accumulators fed by a
//                valid/ready sample port; on request all sums are streamed
//                out in channel order over a valid/ready dump port.
//  Ports       : clk, rst                  - clock / sync active-high reset
//                in_valid_i, in_ready_o    - sample handshake (ready in IDLE)
//                in_chan_i, in_add_i       - target channel and signed addend
//                dump_req_i                - start a dump (IDLE only)
//                out_valid_o, out_ready_i  - dump word handshake
//                out_chan_o, out_sum_o,
//                out_ovf_o, out_last_o     - dump word contents
//                busy_o                    - dump in progress
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_accumulate
  import accum_pkg::*;
#(
  parameter int                      WIDTH         = 16,
  parameter int                      CHANNELS      = 4,
  parameter int                      MODE          = MODE_WRAP,
  parameter logic signed [WIDTH-1:0] HIGH          = {1'b0, {(WIDTH-1){1'b1}}},
  parameter logic signed [WIDTH-1:0] LOW           = {1'b1, {(WIDTH-1){1'b0}}},
  parameter bit                      CLEAR_ON_DUMP = 1'b1,
  localparam int                     CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [CW-1:0]           in_chan_i,
  input  logic signed [WIDTH-1:0] in_add_i,
  input  logic                    dump_req_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CW-1:0]           out_chan_o,
  output logic signed [WIDTH-1:0] out_sum_o,
  output logic                    out_ovf_o,
  output logic                    out_last_o,
  output logic                    busy_o
);

  state_e            state_q, state_d;
  logic [CW-1:0]     chan_q, chan_d;

  logic                    accept;
  logic                    last_word;
  logic                    dump_done;
  logic                    clear_all;
  logic signed [WIDTH-1:0] lane_sum [CHANNELS];
  logic [CHANNELS-1:0]     lane_ovf;

  assign accept    = in_valid_i && (state_q == ST_IDLE);
  assign last_word = (chan_q == CW'(CHANNELS - 1));
  assign dump_done = (state_q == ST_DUMP) && out_ready_i && last_word;
  assign clear_all = dump_done && CLEAR_ON_DUMP;

  // Out-of-range channel numbers match no lane, so such samples vanish
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      accum_lane #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .HIGH  (HIGH),
        .LOW   (LOW)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .add_en_i (accept && (in_chan_i == CW'(gi))),
        .add_i    (in_add_i),
        .clear_i  (clear_all),
        .sum_o    (lane_sum[gi]),
        .ovf_o    (lane_ovf[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        chan_d = '0;
        if (dump_req_i) begin
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        out_valid_o = 1'b1;
        out_last_o  = last_word;
        // Channel pointer only moves on a handshake, so a stalled word holds
        if (out_ready_i) begin
          if (last_word) begin
            state_d = ST_IDLE;
            chan_d  = '0;
          end else begin
            chan_d = chan_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        chan_d  = '0;
      end
    endcase
  end

  // Word mux; chan_q is always a valid channel
  always_comb begin
    out_sum_o = '0;
    out_ovf_o = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_q == CW'(i)) begin
        out_sum_o = lane_sum[i];
        out_ovf_o = lane_ovf[i];
      end
    end
  end

  assign out_chan_o = chan_q;
  assign in_ready_o = (state_q == ST_IDLE);
  assign busy_o     = (state_q == ST_DUMP);

endmodule

`default_nettype wire
